// File: rtl/ps2_keys.sv
// PS/2 set-2 keyboard receiver: synchronises the PS/2 lines, deframes 11-bit frames and holds one
// pressed/released level per game action. Define PS2_WASD_EN to also map A/D/W to left/right/jump.
module ps2_keys #(
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] keys,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic [16:0] TO_LAST = 17'(TIMEOUT_CYC - 1);

  state_t      state;
  logic        clk_s1, clk_s2, clk_prev;
  logic        dat_s1, dat_s2;
  logic        fall;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        par_bit;
  logic [16:0] tcnt;
  logic        ext, brk;
  logic        frame_ok;
  logic        hit;
  logic [1:0]  act;

  // Sync flops reset to the idle-high line level so reset release never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_data;
      dat_s2   <= dat_s1;
    end
  end

  assign fall     = clk_prev & ~clk_s2;
  assign frame_ok = dat_s2 & (^{shreg, par_bit});

  always_comb begin
    hit = 1'b0;
    act = 2'd0;
    if (ext) begin
      case (shreg)
        8'h6B:   begin hit = 1'b1; act = 2'd0; end
        8'h74:   begin hit = 1'b1; act = 2'd1; end
        default: ;
      endcase
    end else begin
      case (shreg)
        8'h12:   begin hit = 1'b1; act = 2'd2; end
        8'h2D:   begin hit = 1'b1; act = 2'd3; end
`ifdef PS2_WASD_EN
        8'h1C:   begin hit = 1'b1; act = 2'd0; end
        8'h23:   begin hit = 1'b1; act = 2'd1; end
        8'h1D:   begin hit = 1'b1; act = 2'd2; end
`else
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tcnt       <= '0;
      ext        <= 1'b0;
      brk        <= 1'b0;
      keys       <= '0;
      code       <= '0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      // A detected edge always beats the timeout, so a frame whose stop edge
      // coincides with expiry still completes.
      if (state != IDLE && !fall) begin
        if (tcnt == TO_LAST) begin
          state     <= IDLE;
          tcnt      <= '0;
          frame_err <= 1'b1;
        end else begin
          tcnt <= tcnt + 17'd1;
        end
      end else begin
        case (state)
          IDLE: begin
            tcnt <= '0;
            if (fall && !dat_s2) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            tcnt    <= '0;
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              state <= PARITY;
          end
          PARITY: begin
            tcnt    <= '0;
            par_bit <= dat_s2;
            state   <= STOP;
          end
          STOP: begin
            tcnt  <= '0;
            state <= IDLE;
            if (frame_ok) begin
              code       <= shreg;
              code_valid <= 1'b1;
              if (shreg == 8'hE0) begin
                ext <= 1'b1;
              end else if (shreg == 8'hF0) begin
                brk <= 1'b1;
              end else begin
                if (hit)
                  keys[act] <= ~brk;
                ext <= 1'b0;
                brk <= 1'b0;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_keys.sv
// Scoreboard bench for ps2_keys: a bench-side key model pushes expected code/keys per good frame,
// and a monitor pops and compares on every code_valid pulse.
module tb_ps2_keys;

  localparam int TO = 200;
  localparam int H  = 8;

  typedef struct {
    logic [7:0] code;
    logic [3:0] keys;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] keys;
  logic [7:0] code;
  logic       code_valid;
  logic       frame_err;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc = 0;
  int   cv_cnt = 0;
  int   ferr_cnt = 0;
  int   last_drop = 0;
  exp_t sb[$];

  logic       m_ext = 1'b0;
  logic       m_brk = 1'b0;
  logic [3:0] m_keys = 4'b0;
  logic [7:0] last_code = 8'h00;

  ps2_keys #(.TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keys      (keys),
    .code      (code),
    .code_valid(code_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && frame_err) ferr_cnt++;
    if (!rst && code_valid) begin
      exp_t e;
      cv_cnt++;
      if (sb.size() == 0) begin
        check("sb_unexpected_cv", 1, 0);
      end else begin
        e = sb.pop_front();
        check("sb_code", code, e.code);
        check("sb_keys", keys, e.keys);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_cyc(H);
    ps2_clk   = 1'b0;
    last_drop = cyc;
    wait_cyc(H);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~(^b) ^ bad_par);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    wait_cyc(6);
  endtask

  task automatic model_byte(input logic [7:0] b);
    int a;
    a = -1;
    if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (m_ext) begin
        if (b == 8'h6B) a = 0;
        else if (b == 8'h74) a = 1;
      end else begin
        case (b)
          8'h12: a = 2;
          8'h2D: a = 3;
`ifdef PS2_WASD_EN
          8'h1C: a = 0;
          8'h23: a = 1;
          8'h1D: a = 2;
`endif
          default: a = -1;
        endcase
      end
      if (a >= 0) m_keys[a] = ~m_brk;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic send_key(input logic [7:0] b);
    exp_t e;
    model_byte(b);
    e.code = b;
    e.keys = m_keys;
    sb.push_back(e);
    last_code = b;
    send_frame(b, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cv0, ferr0, lat;
    logic seen;

    wait_cyc(3);
    check("rst_keys", keys, 0);
    check("rst_code", code, 0);
    check("rst_cv", code_valid, 0);
    check("rst_ferr", frame_err, 0);
    rst = 1'b0;
    wait_cyc(4);

    // Left arrow make then break: five bytes, five code_valid pulses
    cv0 = cv_cnt;
    send_key(8'hE0);
    send_key(8'h6B);
    check("left_make", keys, 4'b0001);
    send_key(8'hE0);
    send_key(8'hF0);
    send_key(8'h6B);
    check("left_break", keys, 4'b0000);
    check("left_cv_count", cv_cnt - cv0, 5);

    // Overlapping Shift and R
    send_key(8'h12);
    check("ovl_shift", keys, 4'b0100);
    send_key(8'h2D);
    check("ovl_both", keys, 4'b1100);
    send_key(8'hF0);
    send_key(8'h12);
    check("ovl_release", keys, 4'b1000);

    // Typematic repeat of a held make code changes nothing
    send_key(8'h2D);
    check("repeat", keys, 4'b1000);

    // Keypad 6B (non-extended) is unmapped
    send_key(8'h6B);
    check("keypad_unmapped", keys, 4'b1000);

    // Bad parity: one frame_err, outputs untouched, then a good frame decodes
    ferr0 = ferr_cnt;
    cv0   = cv_cnt;
    send_frame(8'h6B, 1'b1);
    check("par_ferr", ferr_cnt - ferr0, 1);
    check("par_no_cv", cv_cnt - cv0, 0);
    check("par_code", code, last_code);
    check("par_keys", keys, m_keys);
    send_key(8'hF0);
    send_key(8'h2D);
    check("par_recover", keys, 4'b0000);

    // Timeout: start + 3 data bits, then silence; pulse is TO cycles after the
    // edge is seen, which is 3 synchroniser cycles after the pin fell
    ferr0 = ferr_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    seen = 1'b0;
    lat  = -1;
    for (int i = 0; i < TO + 40 && !seen; i++) begin
      @(negedge clk);
      if (frame_err) begin
        seen = 1'b1;
        lat  = cyc - last_drop;
      end
    end
    check("to_seen", seen, 1);
    check("to_latency", lat, TO + 3);
    wait_cyc(4);
    check("to_ferr_once", ferr_cnt - ferr0, 1);
    send_key(8'hE0);
    send_key(8'h74);
    check("to_recover_right", keys[1], 1);

    send_key(8'hE0);
    send_key(8'h6B);
    check("hold_0011", keys, 4'b0011);

    // Async reset mid-frame: keys clear with no clock edge, leftover bits never decode
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check("rst_async_keys", keys, 0);
    check("rst_async_code", code, 0);
    m_keys = 4'b0;
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    last_code = 8'h00;
    wait_cyc(3);
    rst = 1'b0;
    cv0 = cv_cnt;
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    wait_cyc(TO + 20);
    check("rst_leftover_no_cv", cv_cnt - cv0, 0);
    check("rst_leftover_keys", keys, 0);

    // W: jump only when the WASD option is built in
    send_key(8'h1D);
    check("wasd_code", code, 8'h1D);
`ifdef PS2_WASD_EN
    check("wasd_keys", keys, 4'b0100);
`else
    check("wasd_keys", keys, 4'b0000);
`endif

    wait_cyc(10);
    check("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
